add_serial: RTL and testbench
=============================

ADD_SERIAL -- requirements
Module: add_serial

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; SHALL be >= 2.
REQ-002 Parameter CHUNK, default 4, bits added per clock; WIDTH SHALL be an integer multiple of CHUNK.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request; sampled on rising edge of clk.
REQ-006 sub  input  1  0 = add, 1 = subtract; captured with start.
REQ-007 a  input  WIDTH  operand A, bit 0 = LSB; captured with start.
REQ-008 b  input  WIDTH  operand B, bit 0 = LSB; captured with start.
REQ-009 cin  input  1  carry-in for add; captured with start.
REQ-010 busy  output  1  high while an operation is in progress.
REQ-011 done  output  1  one-cycle pulse; results valid.
REQ-012 out  output  WIDTH  sum/difference.
REQ-013 cout  output  1  carry out of MSB.
REQ-014 ovf  output  1  two's-complement signed overflow.

Function
REQ-015 FSM states: IDLE, BUSY, DONE; N = WIDTH/CHUNK.
REQ-016 IDLE: start=1 -> capture a, b, sub, cin; load chunk counter 0; go BUSY.
REQ-017 BUSY: each cycle adds chunk k (bits k*CHUNK .. k*CHUNK+CHUNK-1) of A and effective B with running carry; writes that chunk of out; k increments.
REQ-018 BUSY: after chunk N-1, go DONE; cout and ovf updated in that same edge.
REQ-019 Latency: start sampled at edge E0 -> done=1 in the cycle after edge EN (N cycles); WIDTH=16, CHUNK=4 -> 4 cycles.
REQ-020 DONE: done=1 for exactly one cycle; start=1 -> capture and go BUSY (back-to-back, no idle gap); else go IDLE.
REQ-021 busy = 1 in BUSY only; done = 1 in DONE only; never both high.
REQ-022 sub=0: result = A + B + cin, modulo 2^WIDTH; cout = bit WIDTH of the full sum.
REQ-023 sub=1: effective B = bitwise NOT B, initial carry = 1, cin ignored; cout = 1 means no borrow (A >= B unsigned).
REQ-024 start during BUSY SHALL be ignored; captured operands unchanged.
REQ-025 Input changes on a, b, sub, cin after capture SHALL NOT affect the result.
REQ-026 out, cout, ovf hold their values from DONE until the next capture; at capture, out SHALL clear to 0 and cout, ovf SHALL clear to 0.
REQ-027 Carry chain within a chunk is combinational; the carry between chunks is registered.

Reset
REQ-028 rst_n=0 SHALL immediately (asynchronously) force state IDLE, chunk counter 0, busy=0, done=0, out=0, cout=0, ovf=0, captured operands 0.
REQ-029 Reset during BUSY SHALL abort the operation; no done pulse is produced for it.
REQ-030 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted.

Configuration
REQ-031 Macro ADD_SERIAL_OVF_EN defined: ovf = (carry into MSB) XOR (carry out of MSB), registered at the final chunk.
REQ-032 Macro ADD_SERIAL_OVF_EN undefined: ovf port still present, tied to 0; no overflow logic synthesised.

Verification (WIDTH=16, CHUNK=4)
REQ-033 a=0x1234, b=0x1111, cin=0, sub=0, start pulse -> done 4 cycles later, out=0x2345, cout=0, ovf=0, busy high for 4 cycles.
REQ-034 a=0xFFFF, b=0x0001, cin=0, sub=0 -> out=0x0000, cout=1, ovf=0; a=0x7FFF, b=0x0001 -> out=0x8000, cout=0, ovf=1 with macro, ovf=0 without.
REQ-035 a=0x0005, b=0x0007, sub=1, cin=1 -> out=0xFFFE, cout=0 (cin ignored); a=0x0007, b=0x0005, sub=1 -> out=0x0002, cout=1.
REQ-036 start held high continuously with a/b changing every cycle -> each result matches operands present at its capture edge; done pulses every 5 cycles (4 BUSY + 1 DONE, back-to-back capture on the DONE cycle).
REQ-037 start pulse, then start=1 with different operands during BUSY -> ignored; single done with first result.
REQ-038 start, then rst_n=0 after 2 BUSY cycles -> busy, done, out, cout, ovf immediately 0; no done pulse; next start after release produces a correct result.

Source files
------------

// File: rtl/add_serial.sv
// Serial adder/subtractor: CHUNK bits per clock, registered carry between chunks; ovf logic only with ADD_SERIAL_OVF_EN.
// Latency: start at edge E0 -> done pulse in the cycle after edge E(WIDTH/CHUNK).
// Backpressure: start is ignored while busy; a start seen in the DONE cycle is accepted back-to-back.
module add_serial #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q;
    logic [KW-1:0]    k_q;
    logic [WIDTH-1:0] a_q, b_q, out_q, out_d;
    logic             carry_q, busy_q, done_q, cout_q;
    logic [CHUNK-1:0] a_chunk, b_chunk;
    logic [CHUNK:0]   sum;
    logic             last;

    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        out_d   = out_q;
        for (int i = 0; i < N; i++) begin
            if (k_q == KW'(i)) begin
                a_chunk = a_q[i*CHUNK +: CHUNK];
                b_chunk = b_q[i*CHUNK +: CHUNK];
            end
        end
        sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
        for (int i = 0; i < N; i++) begin
            if (k_q == KW'(i)) out_d[i*CHUNK +: CHUNK] = sum[CHUNK-1:0];
        end
        last = (k_q == KW'(N - 1));
    end

    // b_q holds the effective operand: already inverted for subtraction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            out_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub ? 1'b1 : cin;
                        k_q     <= '0;
                        out_q   <= '0;
                        cout_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= BUSY;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                BUSY: begin
                    out_q   <= out_d;
                    carry_q <= sum[CHUNK];
                    k_q     <= k_q + KW'(1);
                    if (last) begin
                        cout_q  <= sum[CHUNK];
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef ADD_SERIAL_OVF_EN
    logic ovf_q;
    logic carry_into_msb;

    // Carry into the MSB recovered from the MSB sum bit of the final chunk.
    assign carry_into_msb = sum[CHUNK-1] ^ a_q[WIDTH-1] ^ b_q[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if ((state_q == IDLE || state_q == DONE) && start) begin
            ovf_q <= 1'b0;
        end else if (state_q == BUSY && last) begin
            ovf_q <= carry_into_msb ^ sum[CHUNK];
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign busy = busy_q;
    assign done = done_q;
    assign out  = out_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_add_serial.sv
// Self-checking bench for add_serial (WIDTH=16, CHUNK=4) with a queue-based result scoreboard.
module tb_add_serial;

    localparam int W = 16;
    localparam int C = 4;

    logic         clk = 1'b0;
    logic         rst_n, start, sub, cin;
    logic [W-1:0] a, b;
    logic         busy, done, cout, ovf;
    logic [W-1:0] out;

    int checks = 0;
    int errors = 0;

    logic [W+1:0] sb[$];

    add_serial #(.WIDTH(W), .CHUNK(C)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .out(out), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Reference result packed as {ovf, cout, out}.
    function automatic logic [W+1:0] model(input logic [W-1:0] aa, input logic [W-1:0] bi,
                                           input logic s, input logic ci);
        logic [W-1:0] bb;
        logic [W:0]   full;
        logic         o;
        bb   = s ? ~bi : bi;
        full = {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, (s ? 1'b1 : ci)};
`ifdef ADD_SERIAL_OVF_EN
        o = (aa[W-1] == bb[W-1]) && (full[W-1] != aa[W-1]);
`else
        o = 1'b0;
`endif
        return {o, full[W], full[W-1:0]};
    endfunction

    // Drives a start request at the current negedge and records its expected result.
    task automatic issue(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic s, input logic ci);
        start = 1'b1;
        a     = aa;
        b     = bb;
        sub   = s;
        cin   = ci;
        sb.push_back(model(aa, bb, s, ci));
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        cin   = 1'b0;
        a     = '0;
        b     = '0;
        #12;
        checks++;
        if ({busy, done, cout, ovf, out} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b done=%b cout=%b ovf=%b out=%h want all 0",
                     busy, done, cout, ovf, out);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int nb, lat;
        bit got;
        logic [W+1:0] exp;
        @(negedge clk);
        issue(16'h1234, 16'h1111, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF; sub = 1'b1; cin = 1'b1;
        nb = 0; lat = 0; got = 0;
        for (int i = 0; i < 12 && !got; i++) begin
            if (done) begin
                got = 1;
                lat = i;
                exp = sb.pop_front();
                checks++;
                if ({ovf, cout, out} !== exp) begin
                    errors++;
                    $display("FAIL basic_result got ovf=%b cout=%b out=%h want %h", ovf, cout, out, exp);
                end
            end else begin
                if (busy) nb++;
                @(negedge clk);
            end
        end
        checks++;
        if (!got) begin errors++; $display("FAIL basic_timeout no done within 12 cycles"); end
        checks++;
        if (lat != 4) begin errors++; $display("FAIL basic_latency got %0d want 4", lat); end
        checks++;
        if (nb != 4) begin errors++; $display("FAIL basic_busy_cycles got %0d want 4", nb); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got done=%b want 0", done); end
        repeat (2) @(negedge clk);
        checks++;
        if ({cout, ovf, out} !== {2'b00, 16'h2345}) begin
            errors++;
            $display("FAIL basic_hold got cout=%b ovf=%b out=%h want 0 0 2345", cout, ovf, out);
        end
    endtask

    task automatic test_carry_ovf;
        logic [W-1:0] ta[2] = '{16'hFFFF, 16'h7FFF};
        logic [W-1:0] tb[2] = '{16'h0001, 16'h0001};
        logic [W+1:0] exp;
        bit got;
        for (int t = 0; t < 2; t++) begin
            issue(ta[t], tb[t], 1'b0, 1'b0);
            @(negedge clk);
            start = 1'b0;
            checks++;
            if ({cout, ovf, out} !== '0) begin
                errors++;
                $display("FAIL carry_clear_%0d got cout=%b ovf=%b out=%h want 0", t, cout, ovf, out);
            end
            got = 0;
            for (int i = 0; i < 12 && !got; i++) begin
                if (done) begin
                    got = 1;
                    exp = sb.pop_front();
                    checks++;
                    if ({ovf, cout, out} !== exp) begin
                        errors++;
                        $display("FAIL carry_result_%0d got ovf=%b cout=%b out=%h want %h", t, ovf, cout, out, exp);
                    end
                end else @(negedge clk);
            end
            checks++;
            if (!got) begin errors++; $display("FAIL carry_timeout_%0d no done", t); end
            @(negedge clk);
        end
    endtask

    task automatic test_sub;
        logic [W-1:0] ta[2] = '{16'h0005, 16'h0007};
        logic [W-1:0] tb[2] = '{16'h0007, 16'h0005};
        logic [W+1:0] exp;
        bit got;
        for (int t = 0; t < 2; t++) begin
            issue(ta[t], tb[t], 1'b1, 1'b1);
            @(negedge clk);
            start = 1'b0;
            got = 0;
            for (int i = 0; i < 12 && !got; i++) begin
                if (done) begin
                    got = 1;
                    exp = sb.pop_front();
                    checks++;
                    if ({ovf, cout, out} !== exp) begin
                        errors++;
                        $display("FAIL sub_result_%0d got ovf=%b cout=%b out=%h want %h", t, ovf, cout, out, exp);
                    end
                end else @(negedge clk);
            end
            checks++;
            if (!got) begin errors++; $display("FAIL sub_timeout_%0d no done", t); end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        logic [W+1:0] exp;
        logic [W-1:0] ra, rb;
        logic         rs, rc;
        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom);
            rc = 1'($urandom);
            start = 1'b1; a = ra; b = rb; sub = rs; cin = rc;
            if (i % 5 == 0) sb.push_back(model(ra, rb, rs, rc));
            @(negedge clk);
            checks++;
            if (done !== (i % 5 == 4) || busy !== (i % 5 != 4)) begin
                errors++;
                $display("FAIL b2b_flags_cycle%0d got busy=%b done=%b want busy=%b done=%b",
                         i, busy, done, (i % 5 != 4), (i % 5 == 4));
            end
            if (done && sb.size() > 0) begin
                exp = sb.pop_front();
                checks++;
                if ({ovf, cout, out} !== exp) begin
                    errors++;
                    $display("FAIL b2b_result_cycle%0d got ovf=%b cout=%b out=%h want %h", i, ovf, cout, out, exp);
                end
            end
        end
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL b2b_idle got busy=%b done=%b pending=%0d want 0 0 0", busy, done, sb.size());
        end
    endtask

    task automatic test_ignore_busy;
        logic [W+1:0] exp;
        int ndone;
        issue(16'h0102, 16'h0304, 1'b0, 1'b1);
        @(negedge clk);
        start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1; cin = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) begin
                ndone++;
                if (sb.size() > 0) begin
                    exp = sb.pop_front();
                    checks++;
                    if ({ovf, cout, out} !== exp) begin
                        errors++;
                        $display("FAIL ignore_result got ovf=%b cout=%b out=%h want %h", ovf, cout, out, exp);
                    end
                end
            end
            @(negedge clk);
        end
        checks++;
        if (ndone != 1) begin errors++; $display("FAIL ignore_done_count got %0d want 1", ndone); end
    endtask

    task automatic test_reset_busy;
        logic [W+1:0] exp;
        int lat;
        bit got;
        issue(16'h1111, 16'h2222, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (out !== 16'h0033 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rstbusy_partial got out=%h busy=%b want 0033 1", out, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, cout, ovf, out} !== '0) begin
            errors++;
            $display("FAIL rstbusy_async got busy=%b done=%b cout=%b ovf=%b out=%h want all 0",
                     busy, done, cout, ovf, out);
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        issue(16'h0F0F, 16'h00F1, 1'b0, 1'b1);
        @(negedge clk);
        start = 1'b0;
        got = 0; lat = 0;
        for (int i = 0; i < 12 && !got; i++) begin
            if (done) begin
                got = 1;
                lat = i;
                exp = sb.pop_front();
                checks++;
                if ({ovf, cout, out} !== exp) begin
                    errors++;
                    $display("FAIL rstbusy_result got ovf=%b cout=%b out=%h want %h", ovf, cout, out, exp);
                end
            end else @(negedge clk);
        end
        checks++;
        if (!got || lat != 4) begin
            errors++;
            $display("FAIL rstbusy_latency got done=%b after %0d cycles want done after 4", got, lat);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry_ovf();
        test_sub();
        test_back_to_back();
        test_ignore_busy();
        test_reset_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
